route_request_ctrl: RTL
=======================

Name: route_request_ctrl

Overview:
- Initiator side of the switch route-compute interface.
- Watches every input buffer for a head flit with no route yet and round-robin picks one buffer per cycle.
- Drives that buffer's index to the combinational route-compute unit as buffer_sel and registers the returned out_sel into a per-buffer route table.
- Holds each route until the packet's tail leaves, so the switch allocator reads a stable route_out for every flit of the packet.

Parameters:
- BUFFERS, 4, number of input buffers; also the number of output ports, since out_sel has the same width as buffer_sel; must be >= 2.
- SELW, $clog2(BUFFERS), width of buffer and output indices (derived; do not override).

Ports:
- CLK  input  1  clock.
- RST  input  1  reset, synchronous, active-high.
- head_valid  input  BUFFERS  bit i: buffer i's front entry is a head flit.
- pkt_done  input  BUFFERS  bit i: tail flit of buffer i's current packet left the switch this cycle.
- rc_valid  output  1  a buffer is selected for route compute this cycle.
- buffer_sel  output  SELW  index of the selected buffer; drives the route-compute buffer_sel.
- out_sel  input  SELW  route-compute result for buffer_sel; valid in the same cycle.
- route_valid  output  BUFFERS  bit i: buffer i holds a computed route.
- route_out  output  BUFFERS*SELW  packed; slice i is the output port for buffer i.

Behaviour:
- Synchronous active-high reset on CLK; RST dominates all other inputs.
- Reset values: route_valid = 0, every route_out slice = 0, round-robin pointer = 0.
- Per-buffer state: IDLE (route_valid=0) and ROUTED (route_valid=1).
- Request vector: req[i] = head_valid[i] & ~route_valid[i].
- Arbiter: combinational round-robin.
  - Search starts at the pointer and wraps from BUFFERS-1 to 0.
  - Exactly one grant per cycle when any req bit is set.
- Request outputs:
  - rc_valid = |req.
  - buffer_sel = granted index; buffer_sel = 0 when rc_valid = 0.
- Grant capture: on the edge after a grant to buffer g:
  - route_out[g] <= out_sel, route_valid[g] <= 1, pointer <= (g+1) mod BUFFERS.
- Pointer is unchanged in cycles with no grant.
- Latency: head_valid rising to route_valid high is 1 cycle when uncontended. Worst case is BUFFERS cycles with all buffers requesting.
- Release: pkt_done[i] while route_valid[i] = 1 clears route_valid[i] on the next edge; route_out[i] keeps its stale value.
- pkt_done[i] while route_valid[i] = 0 is ignored.
- Back-to-back packets in one buffer:
  - head_valid[i] asserted in the same cycle as pkt_done[i] is not eligible (route_valid still 1).
  - It becomes eligible the following cycle, so the new route is valid 2 cycles after the pkt_done cycle.
- Multiple pkt_done bits in one cycle: all are honoured independently.
- route_out[i] never changes while route_valid[i] = 1.
- A buffer is never granted while ROUTED.
- Reset mid-operation: all routes are dropped and the pointer returns to 0; requests resume the cycle after RST deasserts.

Optional Feature:
- Macro: RC_PERF_CNT_EN.
- When defined:
  - Extra output perf_routes [15:0], reset to 0.
  - Increments on every edge where rc_valid = 1 and saturates at 16'hFFFF.
  - Extra output perf_stall [15:0]: counts cycles where popcount(req) > 1 (contention), also saturating.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
1. Reset, then head_valid=4'b0100, out_sel=2:
   - Same cycle: rc_valid=1, buffer_sel=2.
   - Next cycle: route_valid=4'b0100, route_out[2]=2.
   - rc_valid=0 while head_valid stays high.
2. Contention: head_valid=4'b1111 from reset, out_sel=buffer_sel^1:
   - Grants in order 0,1,2,3 on consecutive cycles.
   - route_out = {2,3,0,1} (slices 3..0).
   - route_valid reaches 4'b1111 after 4 cycles.
3. Wrap-around: pointer=3 with head_valid=4'b1001 -> grant 3 first, then 0.
4. Release and reuse:
   - Buffer 1 ROUTED; assert pkt_done[1] and head_valid[1] together -> route_valid[1]=0 next cycle.
   - Grant to 1 the cycle after that, with new out_sel=3 captured.
   - pkt_done[2] on an IDLE buffer causes no change.
5. Reset mid-operation:
   - With route_valid=4'b1010, assert RST for one cycle -> route_valid=0, all route_out slices 0.
   - head_valid=4'b1010 still held -> next grant is buffer 1.
6. (RC_PERF_CNT_EN) Scenario 2 -> perf_routes=4, perf_stall=3; preload both counters to 16'hFFFE, run 3 grants -> both read 16'hFFFF.

Source files
------------

// File: rtl/route_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : route_request_ctrl
// Description : Initiator side of the switch route-compute interface.
//               Each cycle, round-robin picks one input buffer that has a
//               head flit but no route yet. It presents that buffer to the
//               combinational route-compute unit and registers the returned
//               output port into a per-buffer route table. A route is held
//               until the packet's tail leaves the switch.
//               Optional macro RC_PERF_CNT_EN adds saturating grant and
//               contention counters (perf_routes, perf_stall).
// Revision    : 1.0 - initial release
// ============================================================================
module route_request_ctrl #(
  parameter int BUFFERS = 4,
  parameter int SELW    = $clog2(BUFFERS)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [BUFFERS-1:0]        head_valid,
  input  logic [BUFFERS-1:0]        pkt_done,
  output logic                      rc_valid,
  output logic [SELW-1:0]           buffer_sel,
  input  logic [SELW-1:0]           out_sel,
  output logic [BUFFERS-1:0]        route_valid,
  output logic [BUFFERS*SELW-1:0]   route_out
`ifdef RC_PERF_CNT_EN
  ,
  output logic [15:0]               perf_routes,
  output logic [15:0]               perf_stall
`endif
);

  // Per-buffer route state: IDLE has no route, ROUTED holds a stable route.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ROUTED = 1'b1
  } buf_state_t;

  localparam logic [SELW-1:0] C_LAST_IDX = SELW'(BUFFERS - 1);
  localparam logic [SELW:0]   C_BUFFERS  = (SELW+1)'(BUFFERS);

  buf_state_t             state_q [BUFFERS];
  buf_state_t             state_d [BUFFERS];
  logic [SELW-1:0]        route_q [BUFFERS];
  logic [SELW-1:0]        rr_ptr;
  logic [BUFFERS-1:0]     req;
  logic [BUFFERS-1:0]     grant_vec;
  logic [SELW-1:0]        grant_idx;
  logic                   grant_found;

  // Request vector and route-table outputs derived from the per-buffer state.
  always_comb begin
    route_valid = '0;
    route_out   = '0;
    req         = '0;
    for (int i = 0; i < BUFFERS; i++) begin
      route_valid[i]                = (state_q[i] == ST_ROUTED);
      route_out[i*SELW +: SELW]     = route_q[i];
      req[i]                        = head_valid[i] & (state_q[i] == ST_IDLE);
    end
  end

  // Round-robin search starting at the pointer, wrapping from the last buffer
  // back to 0; the first requesting buffer found wins.
  always_comb begin
    logic [SELW:0]   sum;
    logic [SELW-1:0] cand;
    grant_idx   = '0;
    grant_found = 1'b0;
    sum         = '0;
    cand        = '0;
    for (int off = 0; off < BUFFERS; off++) begin
      sum = {1'b0, rr_ptr} + (SELW+1)'(off);
      if (sum >= C_BUFFERS) begin
        sum = sum - C_BUFFERS;
      end
      cand = sum[SELW-1:0];
      if (!grant_found && req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Route-compute request interface: index is forced to 0 when idle.
  always_comb begin
    rc_valid   = grant_found;
    buffer_sel = grant_found ? grant_idx : '0;
    grant_vec  = '0;
    for (int i = 0; i < BUFFERS; i++) begin
      grant_vec[i] = grant_found && (grant_idx == SELW'(i));
    end
  end

  // Per-buffer next state: a grant routes an idle buffer, a tail release
  // frees a routed one. Grants never target ROUTED buffers, so the two
  // transitions cannot collide on the same buffer.
  always_comb begin
    for (int i = 0; i < BUFFERS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (grant_vec[i]) begin
            state_d[i] = ST_ROUTED;
          end
        end
        ST_ROUTED: begin
          if (pkt_done[i]) begin
            state_d[i] = ST_IDLE;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  // Per-buffer state register.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < BUFFERS; i++) begin
      if (RST) begin
        state_q[i] <= ST_IDLE;
      end else begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // Route table: captures the route-compute answer for the granted buffer.
  // Released entries keep their stale value until the next grant.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < BUFFERS; i++) begin
      if (RST) begin
        route_q[i] <= '0;
      end else if (grant_vec[i]) begin
        route_q[i] <= out_sel;
      end
    end
  end

  // Round-robin pointer moves just past the winner; held when nothing granted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr <= '0;
    end else if (grant_found) begin
      rr_ptr <= (grant_idx == C_LAST_IDX) ? '0 : grant_idx + SELW'(1);
    end
  end

`ifdef RC_PERF_CNT_EN
  logic contention;

  // Contention means more than one buffer asked for route compute.
  always_comb begin
    contention = ($countones(req) > 1);
  end

  // Saturating counters of issued route computations and contended cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_routes <= '0;
      perf_stall  <= '0;
    end else begin
      if (rc_valid && (perf_routes != 16'hFFFF)) begin
        perf_routes <= perf_routes + 16'd1;
      end
      if (contention && (perf_stall != 16'hFFFF)) begin
        perf_stall <= perf_stall + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
